dot_accum_ctrl: RTL and testbench

DOT_ACCUM_CTRL -- requirements
Module: dot_accum_ctrl

---
 rtl/dot_accum_ctrl.sv | 107 ++++++++++
 tb/tb_dot_accum_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_ctrl.sv
// dot_accum_ctrl: sequences N_TERMS product terms through an external
// accumulate-mux and hands the completed sum to a valid/ready consumer.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake for in_data (8-bit term)
//   mac_x, mac_y           accumulate-mux operands (x = term, y = acc)
//   mac_clear, mac_ld      accumulate-mux selects (mutually exclusive)
//   mac_out                accumulate-mux result, loaded into acc
//   out_valid/out_ready    downstream handshake for out_data (10-bit)
module dot_accum_ctrl #(
   parameter int unsigned N_TERMS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] mac_x,
   output logic [9:0] mac_y,
   output logic       mac_clear,
   output logic       mac_ld,
   input  logic [9:0] mac_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [9:0] out_data
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam logic [1:0] LAST_CNT = 2'(N_TERMS - 1);

   state_e     state_q, state_d;
   logic [9:0] acc_q;
   logic [1:0] cnt_q, cnt_d;

   // acc tracks the mux output every cycle; the mux itself
   // decides hold / add / clear through mac_ld and mac_clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= mac_out;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mac_clear = 1'b0;
      mac_ld    = 1'b0;
      if (rst) begin
         // keep the mux output at zero so nothing is absorbed
         mac_clear = 1'b1;
      end else begin
         case (state_q)
            ACCUM: begin
               in_ready = 1'b1;
               mac_ld   = in_valid;
               if (in_valid) begin
                  if (cnt_q == LAST_CNT) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
            HOLD: begin
               out_valid = 1'b1;
               if (out_ready) begin
                  // clear on the handoff cycle; next term
                  // is taken only after the ACCUM bubble
                  mac_clear = 1'b1;
                  state_d   = ACCUM;
               end
            end
            default: begin
               state_d = ACCUM;
            end
         endcase
      end
   end

   assign mac_x    = in_data;
   assign mac_y    = acc_q;
   assign out_data = acc_q;

   sel_mutex_a: assert property (
      @(posedge clk) !(mac_clear && mac_ld)
   );

   hold_stable_a: assert property (
      @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> $stable(out_data)
   );

endmodule

// File: tb/tb_dot_accum_ctrl.sv
// tb_dot_accum_ctrl: directed scoreboard bench for dot_accum_ctrl
// with a behavioural accumulate-mux, N_TERMS=4 and N_TERMS=1.
module tb_dot_accum_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic       vin0, rdy0, clr0, ld0, ov0, ordy0;
   logic [7:0] din0, x0;
   logic [9:0] y0, mo0, od0;

   logic       vin1, rdy1, clr1, ld1, ov1, ordy1;
   logic [7:0] din1, x1;
   logic [9:0] y1, mo1, od1;

   int n_checks = 0;
   int n_fail   = 0;

   int q0[$];
   int q1[$];

   always #5 clk = ~clk;

   assign mo0 = clr0 ? 10'd0 : (ld0 ? 10'(y0 + {2'b00, x0}) : y0);
   assign mo1 = clr1 ? 10'd0 : (ld1 ? 10'(y1 + {2'b00, x1}) : y1);

   dot_accum_ctrl #(.N_TERMS(4)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(vin0), .in_ready(rdy0), .in_data(din0),
      .mac_x(x0), .mac_y(y0), .mac_clear(clr0), .mac_ld(ld0),
      .mac_out(mo0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0)
   );

   dot_accum_ctrl #(.N_TERMS(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(vin1), .in_ready(rdy1), .in_data(din1),
      .mac_x(x1), .mac_y(y1), .mac_clear(clr1), .mac_ld(ld1),
      .mac_out(mo1),
      .out_valid(ov1), .out_ready(ordy1), .out_data(od1)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int         cnt_m0 = 0;
   logic       pend0 = 0, hold0 = 0, hand0 = 0, gap0 = 0;
   logic [9:0] hold_d0, gap_y0;
   logic       pend1 = 0;
   logic       prev_rst = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", int'(ov0), 0);
         chk("rst_in_ready", int'(rdy0), 0);
         chk("rst_mac_clear", int'(clr0), 1);
         chk("rst_mac_ld", int'(ld0), 0);
         if (prev_rst) chk("rst_acc", int'(y0), 0);
         cnt_m0 = 0;
         pend0  = 0;
         hold0  = 0;
         hand0  = 0;
         gap0   = 0;
         pend1  = 0;
      end else begin
         chk("mutex0", int'(clr0 && ld0), 0);
         chk("mutex1", int'(clr1 && ld1), 0);
         if (vin0) chk("mac_x", int'(x0), int'(din0));
         if (pend0) chk("latency0", int'(ov0), 1);
         if (hold0) begin
            chk("hold_valid", int'(ov0), 1);
            chk("hold_stable", int'(od0), int'(hold_d0));
         end
         if (hand0) begin
            chk("post_valid", int'(ov0), 0);
            chk("post_acc", int'(y0), 0);
         end
         if (gap0) chk("gap_acc", int'(y0), int'(gap_y0));
         if (ov0) begin
            chk("hold_in_ready", int'(rdy0), 0);
            chk("hold_mac_ld", int'(ld0), 0);
            if (ordy0) begin
               chk("handoff_clear", int'(clr0), 1);
               if (q0.size() == 0) begin
                  chk("unexpected_result0", int'(od0), -1);
               end else begin
                  chk("result0", int'(od0), q0.pop_front());
               end
            end
         end
         pend0 = 1'b0;
         if (vin0 && rdy0) begin
            cnt_m0++;
            if (cnt_m0 == 4) begin
               pend0  = 1'b1;
               cnt_m0 = 0;
            end
         end
         hold0   = ov0 && !ordy0;
         hold_d0 = od0;
         hand0   = ov0 && ordy0;
         gap0    = rdy0 && !vin0;
         gap_y0  = y0;

         if (pend1) chk("latency1", int'(ov1), 1);
         if (ov1) begin
            chk("hold_in_ready1", int'(rdy1), 0);
            if (ordy1) begin
               if (q1.size() == 0) begin
                  chk("unexpected_result1", int'(od1), -1);
               end else begin
                  chk("result1", int'(od1), q1.pop_front());
               end
            end
         end
         pend1 = vin1 && rdy1;
      end
      prev_rst = rst;
   end

   // ---------------- drivers ----------------
   task automatic send0(input logic [7:0] t);
      int   k  = 0;
      logic ok = 1'b0;
      vin0 = 1'b1;
      din0 = t;
      do begin
         @(negedge clk);
         ok = rdy0;
         @(posedge clk);
         #1;
         k++;
      end while (!ok && k < 50);
      if (!ok) chk("send0_timeout", 0, 1);
   endtask

   task automatic send1(input logic [7:0] t);
      int   k  = 0;
      logic ok = 1'b0;
      vin1 = 1'b1;
      din1 = t;
      do begin
         @(negedge clk);
         ok = rdy1;
         @(posedge clk);
         #1;
         k++;
      end while (!ok && k < 50);
      if (!ok) chk("send1_timeout", 0, 1);
   endtask

   task automatic idle0(input int n);
      vin0 = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic group0(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input int exp);
      q0.push_back(exp);
      send0(a);
      send0(b);
      send0(c);
      send0(d);
   endtask

   task automatic pulse_rst();
      rst  = 1'b1;
      vin0 = 1'b1;
      din0 = 8'd77;
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
      vin0 = 1'b0;
   endtask

   initial begin
      int k;
      rst   = 1'b1;
      vin0  = 1'b0;
      din0  = 8'd0;
      ordy0 = 1'b1;
      vin1  = 1'b0;
      din1  = 8'd0;
      ordy1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // back-to-back terms
      group0(8'd10, 8'd20, 8'd30, 8'd40, 100);
      // maximum values, no wrap
      group0(8'd255, 8'd255, 8'd255, 8'd255, 1020);
      idle0(3);

      // backpressure with 99s presented while holding
      ordy0 = 1'b0;
      group0(8'd100, 8'd50, 8'd25, 8'd5, 180);
      vin0 = 1'b1;
      din0 = 8'd99;
      repeat (5) @(posedge clk);
      #1;
      ordy0 = 1'b1;
      @(posedge clk);
      #1;
      vin0 = 1'b0;
      group0(8'd5, 8'd5, 8'd5, 8'd5, 20);
      idle0(2);

      // input gaps
      q0.push_back(10);
      send0(8'd1);
      idle0(2);
      send0(8'd2);
      idle0(1);
      send0(8'd3);
      idle0(3);
      send0(8'd4);
      idle0(3);

      // reset mid-accumulation, term offered during reset
      send0(8'd50);
      send0(8'd60);
      idle0(1);
      pulse_rst();
      group0(8'd1, 8'd1, 8'd1, 8'd1, 4);
      idle0(3);

      // reset while a result is pending
      ordy0 = 1'b0;
      send0(8'd7);
      send0(8'd7);
      send0(8'd7);
      send0(8'd7);
      idle0(3);
      pulse_rst();
      ordy0 = 1'b1;
      group0(8'd2, 8'd2, 8'd2, 8'd2, 8);
      idle0(3);

      // single-term instance
      q1.push_back(0);
      send1(8'd0);
      q1.push_back(255);
      send1(8'd255);
      q1.push_back(17);
      send1(8'd17);
      vin1 = 1'b0;

      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
